// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a two-entry skid buffer.
// Load data is aligned and extended as it is captured, so WB only has to pick
// between the ALU result and the finished load value. in_ready comes straight
// from the skid valid flop, so there is no combinational ready path back into MEM.
module wb_pipe_reg #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_ld_data,
    input  logic [2:0]      in_addr_lo,
    input  logic [2:0]      in_funct3,
    input  logic            in_wb_sel,
    input  logic            in_wb_en,
    input  logic [REGW-1:0] in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_wb_en,
    output logic [REGW-1:0] out_rd,
    output logic [XLEN-1:0] out_wb_data,
    output logic [XLEN-1:0] out_alu_out,
    output logic [XLEN-1:0] out_ld_data
);

    typedef struct packed {
        logic [XLEN-1:0] alu_out;
        logic [XLEN-1:0] ld_data;
        logic            wb_sel;
        logic            wb_en;
        logic [REGW-1:0] rd;
    } entry_t;

    entry_t main_q, skid_q, in_e;
    logic   main_v, skid_v;
    logic   accept, pop;

    // Lane selection and extension. Misaligned halfword/word offsets simply
    // drop the low offset bits; the word lane exists only on 64-bit datapaths.
    function automatic logic [XLEN-1:0] ld_extract(
        input logic [XLEN-1:0] w,
        input logic [2:0]      lo,
        input logic [2:0]      f3
    );
        logic [2:0]      b_off, h_off, w_off;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     wd;
        logic [XLEN-1:0] r;
        b_off = (XLEN == 64) ? lo : {1'b0, lo[1:0]};
        h_off = (XLEN == 64) ? {lo[2:1], 1'b0} : {1'b0, lo[1], 1'b0};
        w_off = (XLEN == 64) ? {lo[2], 2'b00} : 3'b000;
        b  = 8'(w >> {b_off, 3'b000});
        h  = 16'(w >> {h_off, 3'b000});
        wd = 32'(w >> {w_off, 3'b000});
        r  = w;
        case (f3)
            3'b000:  r = XLEN'($signed(b));
            3'b001:  r = XLEN'($signed(h));
            3'b010:  r = XLEN'($signed(wd));
            3'b100:  r = XLEN'(b);
            3'b101:  r = XLEN'(h);
            3'b110:  r = (XLEN == 64) ? XLEN'(wd) : w;
            default: r = w;
        endcase
        return r;
    endfunction

    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_v & out_ready;

    // Build the entry as it will be stored; x0 never gets a write enable.
    always_comb begin
        in_e         = '0;
        in_e.alu_out = in_alu_out;
        in_e.ld_data = ld_extract(in_ld_data, in_addr_lo, in_funct3);
        in_e.wb_sel  = in_wb_sel;
        in_e.wb_en   = in_wb_en & (in_rd != '0);
        in_e.rd      = in_rd;
    end

    // Main/skid occupancy and data movement; flush squashes both entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v) begin
            if (accept) begin
                main_q <= in_e;
                main_v <= 1'b1;
            end
        end else if (pop) begin
            if (skid_v) begin
                // in_ready is low while the skid is full, so no accept here
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= in_e;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= in_e;
            skid_v <= 1'b1;
        end
    end

    // Head entry drives WB; data fields are muxed from the stored entry.
    always_comb begin
        out_valid   = main_v;
        out_wb_en   = main_v & main_q.wb_en;
        out_rd      = main_q.rd;
        out_alu_out = main_q.alu_out;
        out_ld_data = main_q.ld_data;
        out_wb_data = main_q.wb_sel ? main_q.ld_data : main_q.alu_out;
    end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Bench for wb_pipe_reg: 32-bit instance checked through a scoreboard,
// 64-bit instance for the wide load lanes and asynchronous reset.
module tb_wb_pipe_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        rst, in_valid, in_ready, in_wb_sel, in_wb_en, flush;
    logic        out_valid, out_ready, out_wb_en;
    logic [31:0] in_alu_out, in_ld_data, out_wb_data, out_alu_out, out_ld_data;
    logic [2:0]  in_addr_lo, in_funct3;
    logic [4:0]  in_rd, out_rd;

    // 64-bit instance
    logic        rst64, v64, rdy64, sel64, en64, fl64, ov64, ordy64, owen64;
    logic [63:0] alu64, ld64, owd64, oalu64, old64;
    logic [2:0]  lo64, f364;
    logic [4:0]  rd64, ord64;

    wb_pipe_reg #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_out(in_alu_out), .in_ld_data(in_ld_data), .in_addr_lo(in_addr_lo),
        .in_funct3(in_funct3), .in_wb_sel(in_wb_sel), .in_wb_en(in_wb_en), .in_rd(in_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
        .out_rd(out_rd), .out_wb_data(out_wb_data), .out_alu_out(out_alu_out),
        .out_ld_data(out_ld_data)
    );

    wb_pipe_reg #(.XLEN(64), .REGW(5)) dut64 (
        .clk(clk), .rst(rst64), .in_valid(v64), .in_ready(rdy64),
        .in_alu_out(alu64), .in_ld_data(ld64), .in_addr_lo(lo64),
        .in_funct3(f364), .in_wb_sel(sel64), .in_wb_en(en64), .in_rd(rd64),
        .flush(fl64), .out_valid(ov64), .out_ready(ordy64), .out_wb_en(owen64),
        .out_rd(ord64), .out_wb_data(owd64), .out_alu_out(oalu64),
        .out_ld_data(old64)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        en;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   pops = 0;

    // Reference 32-bit write-back value built by direct byte/half picking.
    function automatic exp_t model(input logic [31:0] alu, input logic [31:0] ld,
                                   input logic [2:0] lo, input logic [2:0] f3,
                                   input logic sel, input logic en, input logic [4:0] rd);
        exp_t        e;
        int          bo, ho;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] x;
        bo = 8 * int'(lo[1:0]);
        ho = 16 * int'(lo[1]);
        b  = ld[bo +: 8];
        h  = ld[ho +: 16];
        case (f3)
            3'b000:  x = {{24{b[7]}}, b};
            3'b001:  x = {{16{h[15]}}, h};
            3'b100:  x = {24'h0, b};
            3'b101:  x = {16'h0, h};
            default: x = ld;
        endcase
        e.rd   = rd;
        e.en   = en && (rd != 5'd0);
        e.data = sel ? x : alu;
        return e;
    endfunction

    // Scoreboard: compare on consume, enqueue on accept, drop all on flush.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(q.size() != 0), 64'(1));
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_rd", 64'(out_rd), 64'(e.rd));
                    chk("sb_wb_en", 64'(out_wb_en), 64'(e.en));
                    chk("sb_data", 64'(out_wb_data), 64'(e.data));
                end
                pops++;
            end
            if (flush) q.delete();
            else if (in_valid && in_ready)
                q.push_back(model(in_alu_out, in_ld_data, in_addr_lo, in_funct3,
                                  in_wb_sel, in_wb_en, in_rd));
        end
    end

    // Present one entry and hold it until the DUT accepts it (bounded).
    task automatic send(input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] lo,
                        input logic [2:0] f3, input logic sel, input logic en,
                        input logic [4:0] rd);
        logic ok;
        in_alu_out = alu; in_ld_data = ld; in_addr_lo = lo; in_funct3 = f3;
        in_wb_sel  = sel; in_wb_en   = en; in_rd      = rd; in_valid  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) return;
        end
        chk("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_reset32(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_wb_en"}, 64'(out_wb_en), 64'(0));
        chk({tag, "_rd"}, 64'(out_rd), 64'(0));
        chk({tag, "_wb_data"}, 64'(out_wb_data), 64'(0));
        chk({tag, "_alu"}, 64'(out_alu_out), 64'(0));
        chk({tag, "_ld"}, 64'(out_ld_data), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    endtask

    task automatic load64(input logic [63:0] ld, input logic [2:0] lo, input logic [2:0] f3);
        alu64 = 64'h0; ld64 = ld; lo64 = lo; f364 = f3;
        sel64 = 1'b1; en64 = 1'b1; rd64 = 5'd3; v64 = 1'b1;
        @(posedge clk); #1;
        v64 = 1'b0;
    endtask

    int p0;

    initial begin
        rst = 1'b0; rst64 = 1'b0;
        in_valid = 1'b0; in_alu_out = '0; in_ld_data = '0; in_addr_lo = '0; in_funct3 = '0;
        in_wb_sel = 1'b0; in_wb_en = 1'b0; in_rd = '0; flush = 1'b0; out_ready = 1'b0;
        v64 = 1'b0; alu64 = '0; ld64 = '0; lo64 = '0; f364 = '0; sel64 = 1'b0;
        en64 = 1'b0; rd64 = '0; fl64 = 1'b0; ordy64 = 1'b0;
        #1 rst = 1'b1; rst64 = 1'b1;
        #2 chk_reset32("rst_async");
        @(negedge clk); rst = 1'b0; rst64 = 1'b0;
        cycles(1);
        chk_reset32("rst_after");

        // Back-to-back ALU writes, consumed every cycle.
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            send(32'h10 + 32'(i), 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'(i + 1));
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_wb_en", 64'(out_wb_en), 64'(1));
            chk("stream_rd", 64'(out_rd), 64'(i + 1));
            chk("stream_data", 64'(out_wb_data), 64'(32'h10 + 32'(i)));
            chk("stream_in_ready", 64'(in_ready), 64'(1));
        end
        in_valid = 1'b0;
        cycles(2);
        chk("stream_pops", 64'(pops - p0), 64'(4));
        chk("stream_empty", 64'(out_valid), 64'(0));

        // Load extraction.
        send(32'h0, 32'h0000_80FF, 3'd1, 3'b000, 1'b1, 1'b1, 5'd6);
        chk("lb", 64'(out_wb_data), 64'(32'hFFFF_FF80));
        send(32'h0, 32'h0000_80FF, 3'd0, 3'b100, 1'b1, 1'b1, 5'd6);
        chk("lbu", 64'(out_wb_data), 64'(32'h0000_00FF));
        send(32'h0, 32'h0000_80FF, 3'd2, 3'b001, 1'b1, 1'b1, 5'd6);
        chk("lh", 64'(out_wb_data), 64'(32'h0000_0000));
        send(32'hCAFE_0001, 32'h8001_0000, 3'd2, 3'b101, 1'b1, 1'b1, 5'd6);
        chk("lhu", 64'(out_wb_data), 64'(32'h0000_8001));
        chk("lhu_ld", 64'(out_ld_data), 64'(32'h0000_8001));
        chk("lhu_alu", 64'(out_alu_out), 64'(32'hCAFE_0001));
        send(32'h0, 32'hFFFF_8000, 3'd3, 3'b001, 1'b1, 1'b1, 5'd6);
        chk("lh_misaligned", 64'(out_wb_data), 64'(32'hFFFF_FFFF));

        // x0 destination never writes.
        send(32'h55, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd0);
        chk("rd0_valid", 64'(out_valid), 64'(1));
        chk("rd0_wb_en", 64'(out_wb_en), 64'(0));
        in_valid = 1'b0;
        cycles(2);

        // Backpressure: A in main, B in skid, C blocked until drain.
        out_ready = 1'b0;
        send(32'hA1, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd7);
        chk("bp_ready_after_a", 64'(in_ready), 64'(1));
        send(32'hB2, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd8);
        chk("bp_ready_low", 64'(in_ready), 64'(0));
        chk("bp_head_a", 64'(out_rd), 64'(7));
        in_alu_out = 32'hC3; in_rd = 5'd9;
        cycles(2);
        chk("bp_hold_head", 64'(out_wb_data), 64'(32'hA1));
        chk("bp_hold_ready", 64'(in_ready), 64'(0));
        p0 = pops;
        out_ready = 1'b1;
        send(32'hC3, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd9);
        chk("bp_head_c", 64'(out_rd), 64'(9));
        in_valid = 1'b0;
        cycles(2);
        chk("bp_pops", 64'(pops - p0), 64'(3));

        // Flush with both entries held; the flush-cycle input is dropped.
        out_ready = 1'b0;
        send(32'hD4, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd10);
        send(32'hE5, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd11);
        in_alu_out = 32'hF6; in_rd = 5'd12; in_valid = 1'b1; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", 64'(out_valid), 64'(0));
        chk("flush2_ready", 64'(in_ready), 64'(1));
        cycles(1);
        chk("flush2_no_capture", 64'(out_valid), 64'(0));

        // Flush with only main held: in_ready is high, still no capture.
        send(32'h17, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd13);
        in_alu_out = 32'h18; in_rd = 5'd14; in_valid = 1'b1; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_valid", 64'(out_valid), 64'(0));
        cycles(1);
        chk("flush1_no_capture", 64'(out_valid), 64'(0));
        out_ready = 1'b1;
        send(32'h19, 32'h0, 3'd0, 3'b010, 1'b0, 1'b1, 5'd15);
        chk("flush_recover", 64'(out_rd), 64'(15));
        in_valid = 1'b0;
        cycles(2);

        // 64-bit lanes.
        ordy64 = 1'b1;
        load64(64'h8000_0000_1234_5678, 3'd4, 3'b010);
        chk("lw64", owd64, 64'hFFFF_FFFF_8000_0000);
        load64(64'h8000_0000_1234_5678, 3'd4, 3'b110);
        chk("lwu64", owd64, 64'h0000_0000_8000_0000);
        load64(64'h8000_0000_1234_5678, 3'd0, 3'b011);
        chk("ld64", owd64, 64'h8000_0000_1234_5678);
        load64(64'h8000_0000_1234_5678, 3'd7, 3'b000);
        chk("lb64_hi", owd64, 64'hFFFF_FFFF_FFFF_FF80);
        load64(64'h8000_0000_1234_5678, 3'd6, 3'b101);
        chk("lhu64_hi", owd64, 64'h0000_0000_0000_8000);

        // Async reset in the middle of a stream.
        alu64 = 64'h1234; sel64 = 1'b0; en64 = 1'b1; rd64 = 5'd4; v64 = 1'b1;
        cycles(2);
        chk("rst64_pre_wb_en", 64'(owen64), 64'(1));
        rst64 = 1'b1;
        #1;
        chk("rst64_valid", 64'(ov64), 64'(0));
        chk("rst64_wb_en", 64'(owen64), 64'(0));
        chk("rst64_rd", 64'(ord64), 64'(0));
        chk("rst64_wb_data", owd64, 64'h0);
        chk("rst64_alu", oalu64, 64'h0);
        chk("rst64_ld", old64, 64'h0);
        chk("rst64_in_ready", 64'(rdy64), 64'(1));
        v64 = 1'b0;
        @(negedge clk); rst64 = 1'b0;
        cycles(1);

        chk("sb_drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline register for the 5-stage CPU. It captures ALU result, raw load word and write-back control from the MEM stage. Load data is aligned and sign- or zero-extended at capture, and the block presents the final register-file write (`rd`, enable, data) to the WB stage. A 2-entry skid buffer with valid/ready handshake lets WB (or a future cache-miss path) stall without a combinational `ready` path back into MEM. A synchronous flush squashes in-flight entries.

## Interface
Parameters:
- `XLEN`, 32: datapath width; legal values 32 or 64.
- `REGW`, 5: register-index width.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: MEM stage presents an entry.
- `in_ready` output 1: block can accept; driven from a register bit, no combinational dependence on `out_ready`.
- `in_alu_out` input XLEN: ALU result / address.
- `in_ld_data` input XLEN: raw aligned memory word/doubleword.
- `in_addr_lo` input 3: low address bits (byte offset); bit 2 is used only when XLEN=64.
- `in_funct3` input 3: load size/sign encoding.
- `in_wb_sel` input 1: 0 = write ALU result, 1 = write load data.
- `in_wb_en` input 1: entry writes the register file.
- `in_rd` input REGW: destination register.
- `flush` input 1: squash all held entries.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: WB consumes the head entry.
- `out_wb_en` output 1: `out_valid & stored wb_en`.
- `out_rd` output REGW: destination register.
- `out_wb_data` output XLEN: selected write-back value.
- `out_alu_out` output XLEN: stored ALU result.
- `out_ld_data` output XLEN: stored extended load value.

## Operation
- Storage: `main` entry (drives outputs) and `skid` entry, each holding a valid bit and all fields.
- Accept: `in_valid & in_ready & ~flush`. Pop: `out_valid & out_ready`.
- `in_ready = ~skid_valid`.
- Load extraction at capture:
  - Byte lane selected by `in_addr_lo`; halfword lane by `in_addr_lo[2:1]`; word lane by `in_addr_lo[2]` (XLEN=64 only).
  - funct3 000 LB: sign-extend. 001 LH: sign-extend. 010 LW: sign-extend. 100 LBU: zero-extend. 101 LHU: zero-extend. 110 LWU: zero-extend.
  - 011 LD (XLEN=64): full word.
  - Any other code, or 011/110 at XLEN=32: full XLEN word unchanged.
  - Misaligned halfword/word offsets use the truncated lane index; no trap.
- `wb_en` is forced 0 at capture when `in_rd == 0`.
- `out_wb_data = wb_sel ? ld_data : alu_out`; stored fields are muxed combinationally.
- Transitions, evaluated per cycle:
  - Main empty: accept → main.
  - Main full and pop:
    - If skid full: main ← skid; accept is impossible this cycle.
    - Else if accept: main ← input.
    - Else: main empties.
  - Main full, no pop, accept: skid ← input; `in_ready` falls next cycle.
  - Main and skid full, no pop: hold.
- FIFO order is always preserved.
- Flush has priority over everything:
  - Both valid bits clear next cycle.
  - No accept occurs in a flush cycle.
  - Data fields are not required to clear.
- Reset clears all valid bits and all data fields to 0. During and after reset: `out_valid=0`, `out_wb_en=0`, `out_rd=0`, `out_wb_data=0`, `out_alu_out=0`, `out_ld_data=0`, `in_ready=1`.

## Timing
- Latency: accept at edge N → `out_valid=1` with that entry's data after edge N; consumable in cycle N+1.
- Throughput: 1 entry/cycle while `out_ready=1`.
- Backpressure:
  - `in_ready` drops 1 cycle after the skid fills.
  - Exactly one extra entry is absorbed after `out_ready` falls.
- Bubble recovery:
  - After `out_ready` rises with both entries full, the skid drains into main on that edge.
  - `in_ready=1` in the following cycle.
- Simultaneous pop and accept with main full and skid empty: main is replaced; no bubble.
- Async reset mid-operation: outputs go to reset values immediately, not at the next edge.

## Test plan
- Reset, then stream ALU writes rd=1..4 with data 0x10..0x13 and `out_ready=1` → four consecutive `out_wb_en=1` cycles, 1-cycle latency, matching rd/data.
- LB with word 0x0000_80FF at `addr_lo`=1 → 0xFFFF_FF80. LBU at offset 0 → 0x0000_00FF. LH at offset 2 → 0x0000_0000. LHU with word 0x8001_0000 at offset 2 → 0x0000_8001.
- Hold `out_ready=0` while sending A, B, C → A held in main, B in skid, C blocked (`in_ready=0`). Raise `out_ready` → output order A, B, C with no loss or duplication.
- Two entries held, assert `flush` with `in_valid=1` → next cycle `out_valid=0`, `in_ready=1`, the flush-cycle input is not captured.
- Entry with `in_rd=0`, `in_wb_en=1` → `out_valid=1`, `out_wb_en=0`.
- XLEN=64: LW with upper word 0x8000_0000 at `addr_lo`=4 → 0xFFFF_FFFF_8000_0000. LWU → 0x0000_0000_8000_0000. Assert `rst` mid-stream → all outputs 0 asynchronously.
